// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch controller.
package prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH
    } state_t;

    localparam int unsigned FETCH_STEP = 4;

endpackage

// File: rtl/prefetch_ctrl.sv
// Prefetch request/flush controller feeding an external FIFO.
// Optional stall counter enabled by macro PREFETCH_PERF_EN.
module prefetch_ctrl
    import prefetch_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     fetch_en,
    input  logic                     branch,
    input  logic [ADDR_WIDTH-1:0]    branch_addr,
    output logic                     instr_req,
    output logic [ADDR_WIDTH-1:0]    instr_addr,
    input  logic                     instr_gnt,
    input  logic                     instr_rvalid,
    input  logic [31:0]              instr_rdata,
    output logic                     fifo_wr_en,
    output logic [31:0]              fifo_wr_data,
    input  logic [$clog2(DEPTH)-1:0] fifo_wcount,
    input  logic                     fifo_full,
    output logic                     fifo_flush
`ifdef PREFETCH_PERF_EN
    ,
    output logic [31:0]              perf_stall_cnt
`endif
);

    localparam int NW = $clog2(MAX_OUTSTANDING + 2);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(DEPTH + MAX_OUTSTANDING + 2);

    state_t                state_q, state_n;
    logic [NW-1:0]         out_q, out_n;
    logic [NW-1:0]         disc_q, disc_n;
    logic                  req_q, req_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [ADDR_WIDTH-1:0] redir_q, redir_n;
    logic                  rpend_q, rpend_n;

    logic [OW-1:0] occ;
    logic [CW-1:0] occ_n;
    logic          rsp;
    logic          granted;
    logic          credit;
    logic          issue;
    state_t        resume;

    assign occ = fifo_full ? OW'(DEPTH) : OW'(fifo_wcount);

    assign instr_req  = req_q;
    assign instr_addr = addr_q;

    always_comb begin
        // responses with nothing outstanding are stale (e.g. after reset)
        rsp          = instr_rvalid && (out_q != '0);
        granted      = req_q && instr_gnt;
        fifo_flush   = branch;
        fifo_wr_en   = rsp && (state_q != FLUSH) && !branch;
        fifo_wr_data = instr_rdata;

        out_n  = out_q + NW'(granted) - NW'(rsp);
        occ_n  = CW'(occ) + CW'(fifo_wr_en);
        credit = (out_n < NW'(MAX_OUTSTANDING))
              && ((occ_n + CW'(out_n)) < CW'(DEPTH));
        issue  = (state_q == FETCH) && fetch_en && !branch
              && (!req_q || instr_gnt) && credit;
        req_n  = (req_q && !instr_gnt) || issue;

        addr_n  = addr_q;
        redir_n = redir_q;
        rpend_n = rpend_q;
        if (branch && (!req_q || instr_gnt)) begin
            addr_n  = branch_addr;
            rpend_n = 1'b0;
        end else if (branch) begin
            // bus address must hold until the pending request is taken
            redir_n = branch_addr;
            rpend_n = 1'b1;
        end else if (granted) begin
            addr_n  = rpend_q ? redir_q
                              : addr_q + ADDR_WIDTH'(FETCH_STEP);
            rpend_n = 1'b0;
        end

        disc_n = disc_q;
        if (branch) begin
            disc_n = out_q + NW'(req_q) - NW'(rsp);
        end else if (state_q == FLUSH) begin
            disc_n = disc_q - NW'(rsp);
        end

        resume  = fetch_en ? FETCH : IDLE;
        state_n = state_q;
        if (branch || (state_q == FLUSH)) begin
            state_n = (disc_n != '0) ? FLUSH : resume;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fetch_en) state_n = FETCH;
                end
                FETCH: begin
                    if (!fetch_en && (out_n == '0) && !req_n)
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            disc_q  <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            redir_q <= '0;
            rpend_q <= 1'b0;
        end else begin
            state_q <= state_n;
            out_q   <= out_n;
            disc_q  <= disc_n;
            req_q   <= req_n;
            addr_q  <= addr_n;
            redir_q <= redir_n;
            rpend_q <= rpend_n;
        end
    end

`ifdef PREFETCH_PERF_EN
    logic [31:0] stall_q;
    logic        stall;

    assign stall = (state_q == FETCH) && fetch_en && !branch
                && !(req_q && !instr_gnt) && !credit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (stall && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_q;
`endif

endmodule

// File: doc/prefetch_ctrl.md
PREFETCH_CTRL -- requirements
Module: prefetch_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 4, entry count of the attached prefetch FIFO (power of 2, >=2)
- ADDR_WIDTH, 32, fetch address width
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered bus requests (>=1)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on rising edge
- reset_n, in, 1, synchronous active-low reset
- fetch_en, in, 1, enable fetching
- branch, in, 1, redirect pulse
- branch_addr, in, ADDR_WIDTH, redirect target
- instr_req, out, 1, bus request
- instr_addr, out, ADDR_WIDTH, bus address
- instr_gnt, in, 1, request accepted
- instr_rvalid, in, 1, response valid
- instr_rdata, in, 32, response data
- fifo_wr_en, out, 1, push to FIFO
- fifo_wr_data, out, 32, push data
- fifo_wcount, in, $clog2(DEPTH), FIFO occupancy
- fifo_full, in, 1, FIFO full
- fifo_flush, out, 1, clear FIFO contents

Function
REQ-003 FSM states SHALL be IDLE, FETCH, FLUSH; IDLE->FETCH when fetch_en=1; FETCH->IDLE when fetch_en=0 and no outstanding; any state->FLUSH on branch when in-flight count after the branch cycle >0, else ->FETCH (or IDLE if fetch_en=0); FLUSH->FETCH/IDLE when discard count reaches 0.
REQ-004 Occupancy SHALL be DEPTH when fifo_full=1, else fifo_wcount.
REQ-005 A new request SHALL be raised in FETCH only when outstanding<MAX_OUTSTANDING and occupancy+outstanding<DEPTH (credit rule); FIFO overflow SHALL be impossible.
REQ-006 Once instr_req=1, instr_req and instr_addr SHALL hold stable until instr_gnt=1, including across branch and fetch_en deassertion.
REQ-007 On grant, instr_addr SHALL advance by 4; outstanding SHALL increment; wrap at 2^ADDR_WIDTH SHALL be modular.
REQ-008 On instr_rvalid with discard=0, fifo_wr_en=1 and fifo_wr_data=instr_rdata combinationally in the same cycle (zero latency); outstanding decrements.
REQ-009 Grant and rvalid in the same cycle SHALL leave outstanding unchanged.
REQ-010 On branch: fifo_flush=1 for exactly that cycle; discard<=in-flight count (outstanding plus a pending ungranted request); next-issue address<=branch_addr after any pending request is granted.
REQ-011 In FLUSH, each rvalid SHALL decrement discard with fifo_wr_en=0; no new requests.
REQ-012 A branch during FLUSH SHALL reload the target and keep the accumulated discard count; the cycle with branch and rvalid both high SHALL discard that response.
REQ-013 fifo_wr_en and fifo_flush SHALL never both be 1 in the same cycle.

Reset
REQ-014 With reset_n=0 at a clk edge: state=IDLE, outstanding=0, discard=0, instr_addr=0, instr_req=0, fifo_wr_en=0, fifo_flush=0.
REQ-015 Reset mid-transaction SHALL abandon all in-flight requests; responses arriving after reset SHALL be ignored until a new grant occurs.

Configuration
REQ-016 Macro PREFETCH_PERF_EN defined: extra output perf_stall_cnt (32 bits, reset 0, saturating) SHALL count cycles in FETCH with fetch_en=1 and the request blocked by the credit rule; undefined: port and counter absent, all other behaviour identical.

Structure
REQ-017 Shared package prefetch_pkg SHALL hold the FSM state enum (IDLE/FETCH/FLUSH) and the fetch step constant (4).
REQ-018 No sub-module; the FIFO SHALL be instantiated by the parent beside this block.

Verification
REQ-019 Reset, fetch_en=1, gnt always 1, rvalid one cycle after gnt, FIFO never popped -> exactly 4 pushes at addresses 0,4,8,12, then instr_req=0.
REQ-020 2 requests outstanding, branch to 0x100 -> fifo_flush 1 cycle, next 2 rvalids produce no push, next request addr=0x100.
REQ-021 instr_req=1 with gnt held 0 for 5 cycles, branch mid-wait -> addr unchanged until gnt, that response discarded.
REQ-022 Same-cycle gnt and rvalid with MAX_OUTSTANDING=2 -> outstanding stays 1, continuous 1 push per cycle.
REQ-023 reset_n=0 for one cycle while 2 requests are outstanding -> all outputs reset next cycle, late rvalids cause no push.
REQ-024 PREFETCH_PERF_EN defined, FIFO full for 10 cycles with fetch_en=1 -> perf_stall_cnt=10.
